hex_display_scanner: RTL and testbench



---
 rtl/hex_display_pkg.sv | 24 ++
 rtl/hex_display_scanner_hex_decoder.sv | 35 +++
 rtl/hex_display_scanner.sv | 168 ++++++++++++++++
 tb/tb_hex_display_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_display_pkg;

  // Upper bound on the digit count; the shadow record is sized for it so the
  // package needs no parameters.
  localparam int MAX_DIGITS = 8;
  localparam int VAL_W      = 4 * MAX_DIGITS;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One captured display image: nibbles, decimal points and blank requests.
  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [MAX_DIGITS-1:0] dp;
    logic [MAX_DIGITS-1:0] blank_mask;
  } shadow_rec_t;

  // Width of the digit index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_display_scanner_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  // Segment lookup for the selected nibble.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output
    // unassigned, which would infer a latch.
    o_seg_n = SEG_BLANK;
    case (i_nibble)
      4'h0:    o_seg_n = 7'h40;
      4'h1:    o_seg_n = 7'h79;
      4'h2:    o_seg_n = 7'h24;
      4'h3:    o_seg_n = 7'h30;
      4'h4:    o_seg_n = 7'h19;
      4'h5:    o_seg_n = 7'h12;
      4'h6:    o_seg_n = 7'h02;
      4'h7:    o_seg_n = 7'h58;
      4'h8:    o_seg_n = 7'h00;
      4'h9:    o_seg_n = 7'h10;
      4'hA:    o_seg_n = 7'h08;
      4'hB:    o_seg_n = 7'h03;
      4'hC:    o_seg_n = 7'h27;
      4'hD:    o_seg_n = 7'h21;
      4'hE:    o_seg_n = 7'h06;
      4'hF:    o_seg_n = 7'h0E;
      default: o_seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display with
// frame-aligned double buffering, anti-ghost dead time, leading-zero
// suppression and whole-display blink.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  blink_en,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = idx_width(N_DIGITS);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

  // Reject configurations the scan logic cannot honour.
  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("hex_display_scanner: N_DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("hex_display_scanner: SCAN_DIV must be >= 2");
  end
  if (DEAD_CYCLES < 0 || DEAD_CYCLES >= SCAN_DIV) begin : g_bad_dead
    $error("hex_display_scanner: DEAD_CYCLES must be 0..SCAN_DIV-1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("hex_display_scanner: BLINK_FRAMES must be >= 1");
  end

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  shadow_rec_t         r_pending;
  logic                r_pending_valid;
  shadow_rec_t         r_shadow;
  logic [FRM_W-1:0]    r_frame_cnt;
  logic                r_blink_on;
  logic [6:0]          r_seg_n;
  logic                r_dp_n;
  logic [N_DIGITS-1:0] r_an_n;
  logic                r_frame_start;

  logic                w_slot_wrap;
  logic                w_last_digit;
  logic                w_frame_wrap;
  shadow_rec_t         w_load_rec;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_lit;
  logic                w_upper_zero;
  logic                w_dark;

  assign w_slot_wrap  = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_last_digit = (r_idx == IDX_W'(N_DIGITS - 1));
  // The edge that leaves the last slot of the last digit starts a new frame.
  assign w_frame_wrap = w_slot_wrap && w_last_digit;

  // Zero-extend the live inputs into a full-width record for capture.
  always_comb begin
    w_load_rec                            = '0;
    w_load_rec.value[4*N_DIGITS-1:0]      = value;
    w_load_rec.dp[N_DIGITS-1:0]           = dp;
    w_load_rec.blank_mask[N_DIGITS-1:0]   = blank_mask;
  end

  // Scan position: slot counter and digit index.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= w_last_digit ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer: loads land in pending, commit to shadow only at frame wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_shadow        <= '0;
    end else begin
      if (w_frame_wrap && r_pending_valid) begin
        r_shadow <= r_pending;
      end
      // A load on the commit edge keeps its data pending for the next frame.
      if (load) begin
        r_pending       <= w_load_rec;
        r_pending_valid <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pending_valid <= 1'b0;
      end
    end
  end

  // Blink timebase: counts frames and flips the phase every BLINK_FRAMES.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_wrap) begin
      if (r_frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_nibble = r_shadow.value[{r_idx, 2'b00} +: 4];

  hex_decoder u_hex_decoder (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_lit)
  );

  // Darkness of the current digit: blank mask, blink-off phase, or a leading zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i >= int'(r_idx) && r_shadow.value[4*i +: 4] != 4'h0) begin
        w_upper_zero = 1'b0;
      end
    end
    w_dark = r_shadow.blank_mask[r_idx]
          || (blink_en && !r_blink_on)
          || (lz_en && (r_idx != '0) && w_upper_zero);
  end

  // Registered pin drivers, one cycle behind the scan position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_n       <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_an_n        <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_seg_n       <= w_dark ? SEG_BLANK : w_seg_lit;
      r_dp_n        <= w_dark | ~r_shadow.dp[r_idx];
      r_an_n        <= (r_cnt >= CNT_W'(DEAD_CYCLES)) ? ~(N_DIGITS'(1) << r_idx) : '1;
      r_frame_start <= (r_cnt == '0) && (r_idx == '0);
    end
  end

  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;
  assign an_n        = r_an_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench: a cycle-count based reference model predicts every
// output each cycle; directed literal checks pin the model's behaviour.
module tb_hex_display_scanner;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int BLINK = 2;
  localparam int FRAME = DIV * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic [3:0]    blank_mask;
  logic          load;
  logic          lz_en;
  logic          blink_en;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          frame_start;

  hex_display_scanner #(
    .N_DIGITS     (N),
    .SCAN_DIV     (DIV),
    .DEAD_CYCLES  (DEAD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp          (dp),
    .blank_mask  (blank_mask),
    .load        (load),
    .lz_en       (lz_en),
    .blink_en    (blink_en),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  logic check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  int         m_e;          // clock edges since reset release = scan position
  logic [15:0] m_pend_v, m_sh_v;
  logic [3:0]  m_pend_dp, m_sh_dp, m_pend_bm, m_sh_bm;
  logic        m_pv;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fs;
  logic [3:0]  exp_an;
  int          shown_cnt = -1;
  int          shown_idx = -1;

  always @(posedge clk) begin
    int  cnt, idx, frame;
    bit  phase_on, dark, commit;
    if (reset) begin
      m_e = 0; m_pv = 1'b0;
      m_pend_v = '0; m_pend_dp = '0; m_pend_bm = '0;
      m_sh_v = '0; m_sh_dp = '0; m_sh_bm = '0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
      shown_cnt = -1; shown_idx = -1;
    end else begin
      cnt      = m_e % DIV;
      idx      = (m_e / DIV) % N;
      frame    = m_e / FRAME;
      phase_on = ((frame / BLINK) % 2) == 0;
      dark     = m_sh_bm[idx] || (blink_en && !phase_on)
              || (lz_en && idx > 0 && (m_sh_v >> (4 * idx)) == 0);
      exp_seg  = dark ? 7'h7F : seg_tab[m_sh_v[4*idx +: 4]];
      exp_dp   = dark ? 1'b1 : !m_sh_dp[idx];
      exp_an   = (cnt >= DEAD) ? ~(4'b0001 << idx) : 4'hF;
      exp_fs   = (cnt == 0 && idx == 0);
      shown_cnt = cnt;
      shown_idx = idx;
      commit = ((m_e + 1) % FRAME) == 0;
      if (commit && m_pv) begin
        m_sh_v = m_pend_v; m_sh_dp = m_pend_dp; m_sh_bm = m_pend_bm;
      end
      if (load) begin
        m_pend_v = value; m_pend_dp = dp; m_pend_bm = blank_mask; m_pv = 1'b1;
      end else if (commit) begin
        m_pv = 1'b0;
      end
      m_e++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("seg_n", 32'(seg_n), 32'(exp_seg));
      check("dp_n", 32'(dp_n), 32'(exp_dp));
      check("an_n", 32'(an_n), 32'(exp_an));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance at least one cycle, until the outputs show slot (c, i).
  task automatic wait_state(input int c, input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(shown_cnt == c && shown_idx == i) && n < 200);
    if (!(shown_cnt == c && shown_idx == i)) check("wait_timeout", 32'd0, 32'd1);
  endtask

  // Pulse load for one cycle, then run to the commit edge.
  task automatic load_commit(input logic [15:0] v, input logic [3:0] d, input logic [3:0] bm);
    value = v; dp = d; blank_mask = bm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_state(7, 3);
  endtask

  // Check digit seg_n literals at mid-slot of one frame, digits 0..3.
  task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    wait_state(3, 0); check({name, "_d0"}, 32'(seg_n), 32'(s0));
    wait_state(3, 1); check({name, "_d1"}, 32'(seg_n), 32'(s1));
    wait_state(3, 2); check({name, "_d2"}, 32'(seg_n), 32'(s2));
    wait_state(3, 3); check({name, "_d3"}, 32'(seg_n), 32'(s3));
  endtask

  initial begin
    int dark_frames;
    bit found;
    reset = 1'b1; value = '0; dp = '0; blank_mask = '0;
    load = 1'b0; lz_en = 1'b0; blink_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg_n), 32'h7F);
    check("reset_an", 32'(an_n), 32'hF);
    check("reset_dp", 32'(dp_n), 32'h1);
    check("reset_fs", 32'(frame_start), 32'h0);
    reset = 1'b0;
    check_en = 1'b1;

    // Reset release, no load: zeros, dead time, scan order, frame pulse.
    @(negedge clk);
    check("first_fs", 32'(frame_start), 32'h1);
    check("first_dead_an", 32'(an_n), 32'hF);
    wait_state(2, 0);
    check("scan0_an", 32'(an_n), 32'hE);
    check("scan0_seg", 32'(seg_n), 32'h40);
    wait_state(2, 1); check("scan1_an", 32'(an_n), 32'hD);
    wait_state(2, 3); check("scan3_an", 32'(an_n), 32'h7);

    // Mid-frame load only appears from the next frame.
    value = 16'h12AF; dp = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_state(5, 3); check("no_tear_seg", 32'(seg_n), 32'h40);
    wait_state(3, 0); check("load_d0", 32'(seg_n), 32'h0E);
    wait_state(3, 1); check("load_d1", 32'(seg_n), 32'h08);
    wait_state(3, 2); check("load_d2", 32'(seg_n), 32'h24);
    check("load_d2_dp", 32'(dp_n), 32'h0);
    wait_state(3, 3); check("load_d3", 32'(seg_n), 32'h79);

    // Leading-zero suppression.
    lz_en = 1'b1;
    load_commit(16'h0030, 4'b0000, 4'b0000);
    check_frame("lz_0030", 7'h40, 7'h30, 7'h7F, 7'h7F);
    load_commit(16'h0000, 4'b0000, 4'b0000);
    check_frame("lz_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F);

    // Blank mask keeps the anode scanning.
    lz_en = 1'b0;
    load_commit(16'h8888, 4'b0000, 4'b0010);
    check_frame("bm_8888", 7'h00, 7'h7F, 7'h00, 7'h00);
    wait_state(3, 1); check("bm_an", 32'(an_n), 32'hD);

    // Blink: over any four consecutive frames exactly two are dark.
    blink_en = 1'b1;
    dark_frames = 0;
    for (int f = 0; f < 4; f++) begin
      wait_state(3, 0);
      if (seg_n == 7'h7F) dark_frames++;
    end
    check("blink_dark_frames", 32'(dark_frames), 32'd2);
    found = 1'b0;
    for (int f = 0; f < 4 && !found; f++) begin
      wait_state(3, 0);
      if (seg_n == 7'h7F) found = 1'b1;
    end
    check("blink_found_dark", 32'(found), 32'd1);
    blink_en = 1'b0;
    @(negedge clk);
    check("blink_relight", 32'(seg_n), 32'h00);

    // Load on the commit edge, then reset mid-slot.
    wait_state(0, 0);
    value = 16'h1111; dp = '0; blank_mask = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_state(6, 3);
    value = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_state(3, 1); check("commit_edge_old", 32'(seg_n), 32'h79);
    wait_state(4, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_seg", 32'(seg_n), 32'h7F);
    check("midreset_an", 32'(an_n), 32'hF);
    check("midreset_dp", 32'(dp_n), 32'h1);
    reset = 1'b0;
    check_frame("after_reset_f0", 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("after_reset_f1", 7'h40, 7'h40, 7'h40, 7'h40);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load       = ($urandom % 8) == 0;
      value      = 16'($urandom);
      dp         = 4'($urandom);
      blank_mask = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      if (($urandom % 40) == 0) lz_en = ~lz_en;
      if (($urandom % 40) == 0) blink_en = ~blink_en;
      reset      = ($urandom % 400) == 0;
    end
    @(negedge clk);
    load = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
